// File: rtl/ej9_if.sv
// ============================================================================
// Module      : ej9_if
// Description : Signal bundle for the ej9 logic block: five Boolean inputs,
//               eight function outputs and the registered mismatch flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ej9_if;
  logic A;
  logic B;
  logic C;
  logic D;
  logic E;
  logic f;
  logic g;
  logic h;
  logic i;
  logic fk;
  logic gk;
  logic hk;
  logic ik;
  logic err;

  modport master (
    output A, B, C, D, E,
    input  f, g, h, i, fk, gk, hk, ik, err
  );

  modport slave (
    input  A, B, C, D, E,
    output f, g, h, i, fk, gk, hk, ik, err
  );
endinterface

`default_nettype wire

// File: rtl/ej9.sv
// ============================================================================
// Module      : ej9
// Description : Four 5-input Boolean functions, each in canonical and in
//               minimised form, with a sticky registered disagreement flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ej9 (
  input  logic   clk,
  input  logic   reset,
  ej9_if.slave   bus
);

  // Bit k set <=> index k is a listed minterm (f,g,h) or maxterm (i).
  localparam logic [31:0] C_F_MINTERMS = 32'hA5A5_A5A5;
  localparam logic [31:0] C_G_MINTERMS = 32'hFF22_2222;
  localparam logic [31:0] C_H_MINTERMS = 32'h4400_F4F0;
  localparam logic [31:0] C_I_MAXTERMS = 32'h0F00_5F55;

  logic [4:0]  w_n;
  logic [31:0] w_minterm;
  logic [31:0] w_maxterm;
  logic        w_f;
  logic        w_g;
  logic        w_h;
  logic        w_i;
  logic        w_fk;
  logic        w_gk;
  logic        w_hk;
  logic        w_ik;
  logic        err_d;
  logic        err_q;

  assign w_n = {bus.A, bus.B, bus.C, bus.D, bus.E};

  // One full 5-literal product and one full 5-literal sum per index.
  for (genvar k = 0; k < 32; k++) begin : g_term
    localparam logic [4:0] C_K = 5'(k);
    assign w_minterm[k] = &(w_n ~^ C_K);
    assign w_maxterm[k] = |(w_n ^ C_K);
  end

  assign w_f = |(w_minterm & C_F_MINTERMS);
  assign w_g = |(w_minterm & C_G_MINTERMS);
  assign w_h = |(w_minterm & C_H_MINTERMS);
  assign w_i = &(w_maxterm | ~C_I_MAXTERMS);

  assign w_fk = (bus.C & bus.E) | (~bus.C & ~bus.E);
  assign w_gk = (bus.A & bus.B) | (~bus.D & bus.E);
  assign w_hk = (~bus.A & bus.C) | (bus.B & bus.D & ~bus.E);
  assign w_ik = (bus.A | bus.E) & (~bus.B | bus.C);

  always_comb begin
    err_d = err_q | (w_f ^ w_fk) | (w_g ^ w_gk) | (w_h ^ w_hk) | (w_i ^ w_ik);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.f   = w_f;
  assign bus.g   = w_g;
  assign bus.h   = w_h;
  assign bus.i   = w_i;
  assign bus.fk  = w_fk;
  assign bus.gk  = w_gk;
  assign bus.hk  = w_hk;
  assign bus.ik  = w_ik;
  assign bus.err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ej9.sv
// ============================================================================
// Module      : tb_ej9
// Description : Self-checking bench for ej9: set-membership reference model,
//               exhaustive and random input sweeps, sticky flag injection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ej9;

  logic clk;
  logic reset;
  ej9_if bus ();

  ej9 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;
  bit forcing = 1'b0;
  bit exp_err = 1'b0;

  int F_SET[16] = '{0, 2, 5, 7, 8, 10, 13, 15, 16, 18, 21, 23, 24, 26, 29, 31};
  int G_SET[14] = '{1, 5, 9, 13, 17, 21, 24, 25, 26, 27, 28, 29, 30, 31};
  int H_SET[11] = '{4, 5, 6, 7, 10, 12, 13, 14, 15, 26, 30};
  int I_SET[14] = '{0, 2, 4, 6, 8, 9, 10, 11, 12, 14, 24, 25, 26, 27};

  // which: 0=F 1=G 2=H 3=I (I lists maxterms, so membership means 0)
  function automatic bit model(int which, int n);
    bit hit;
    hit = 1'b0;
    case (which)
      0: foreach (F_SET[k]) if (F_SET[k] == n) hit = 1'b1;
      1: foreach (G_SET[k]) if (G_SET[k] == n) hit = 1'b1;
      2: foreach (H_SET[k]) if (H_SET[k] == n) hit = 1'b1;
      default: foreach (I_SET[k]) if (I_SET[k] == n) hit = 1'b1;
    endcase
    return (which == 3) ? !hit : hit;
  endfunction

  task automatic chk(input string name, input int n, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s n=%0d actual=%b required=%b t=%0t", name, n, act, exp, $time);
    end
  endtask

  task automatic apply(input int n);
    @(posedge clk);
    #2;
    {bus.A, bus.B, bus.C, bus.D, bus.E} = 5'(n);
  endtask

  // Sticky flag expectation: set only by an edge that sees an injected mismatch.
  always @(posedge clk or posedge reset) begin
    if (reset) exp_err <= 1'b0;
    else if (forcing) exp_err <= 1'b1;
  end

  always @(negedge clk) begin
    int n;
    if (started) begin
      n = int'({bus.A, bus.B, bus.C, bus.D, bus.E});
      chk("f", n, bus.f, model(0, n));
      chk("g", n, bus.g, model(1, n));
      chk("h", n, bus.h, model(2, n));
      chk("i", n, bus.i, model(3, n));
      if (!forcing) begin
        chk("fk", n, bus.fk, model(0, n));
        chk("gk", n, bus.gk, model(1, n));
        chk("hk", n, bus.hk, model(2, n));
        chk("ik", n, bus.ik, model(3, n));
      end
      chk("err", n, bus.err, exp_err);
    end
  end

  task automatic lit(input int n, input logic ef, input logic eg, input logic eh, input logic ei);
    apply(n);
    #1;
    chk("lit_f", n, bus.f, ef);
    chk("lit_g", n, bus.g, eg);
    chk("lit_h", n, bus.h, eh);
    chk("lit_i", n, bus.i, ei);
  endtask

  initial begin
    reset = 1'b1;
    {bus.A, bus.B, bus.C, bus.D, bus.E} = 5'd0;
    repeat (3) @(posedge clk);
    #2;
    started = 1'b1;

    // Outputs must track inputs while reset is held.
    for (int k = 0; k < 16; k++) apply(int'($urandom_range(0, 31)));
    #1;
    chk("err_in_reset", 0, bus.err, 1'b0);

    apply(0);
    reset = 1'b0;

    lit(0,  1'b1, 1'b0, 1'b0, 1'b0);
    lit(31, 1'b1, 1'b1, 1'b0, 1'b1);
    lit(5,  1'b1, 1'b1, 1'b1, 1'b1);
    lit(26, 1'b1, 1'b1, 1'b1, 1'b0);

    // Exhaustive sweep, 100 ns per code.
    for (int n = 0; n < 32; n++) begin
      apply(n);
      repeat (9) @(posedge clk);
    end

    for (int k = 0; k < 200; k++) apply(int'($urandom_range(0, 31)));
    @(negedge clk);
    #1;
    chk("err_after_sweep", 0, bus.err, 1'b0);

    // Inject one cycle of fk = ~f at n=0 (f=1).
    apply(0);
    force dut.w_fk = 1'b0;
    forcing = 1'b1;
    @(posedge clk);
    #2;
    release dut.w_fk;
    forcing = 1'b0;
    #1;
    chk("err_set", 0, bus.err, 1'b1);
    repeat (5) @(posedge clk);
    #2;
    chk("err_sticky", 0, bus.err, 1'b1);

    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("err_async_clear", 0, bus.err, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    for (int k = 0; k < 20; k++) apply(int'($urandom_range(0, 31)));
    @(negedge clk);
    #1;

    started = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
